dm_bus_arbiter: RTL
===================

# dm_bus_arbiter

Two-port arbiter and access sequencer for the single data-memory/MIO bus. It shares that bus between the CPU data port (port 0) and a loader/debug master (port 1). Each granted request becomes one sequenced memory access with a fixed read latency and a one-cycle acknowledge. It also produces the CPU stall that replaces the unused `MIO_ready` path of the single-cycle core.

## Interface
- `AW`, 32: address width; addresses are word addresses, matching the core's `Addr_out`.
- `RD_LAT`, 1: memory read latency in cycles. Legal range is 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request. Hold high until the port's ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_wea`, `p1_wea`  in  4  byte write enables (writes only).
- `p0_addr`, `p1_addr`  in  AW  word address.
- `p0_wdata`, `p1_wdata`  in  32  write data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  32  read data, valid with ack and held until that port's next ack.
- `cpu_stall`  out  1  `p0_req & ~p0_ack` (combinational).
- `mem_req`  out  1  memory access strobe, high exactly one cycle per access.
- `mem_we`  out  1  write strobe; valid only with `mem_req`.
- `mem_wea`  out  4  byte enables; forced to 0 on reads.
- `mem_addr`  out  AW  latched address.
- `mem_wdata`  out  32  latched write data.
- `mem_rdata`  in  32  read data, valid `RD_LAT` cycles after the `mem_req` cycle.
- `busy`  out  1  1 whenever the FSM is not in IDLE.
- `owner`  out  1  port currently or last granted.

## Operation
- FSM has four states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any request is high, pick a winner and latch `we`, `wea`, `addr` and `wdata` from that port.
  - Set `owner` to the winner and go to ACCESS.
  - If no request is high, stay in IDLE.
- ACCESS:
  - `mem_req` = 1 and the latched fields drive the `mem_*` outputs.
  - A write goes to DONE.
  - A read loads the counter with `RD_LAT` and goes to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `mem_rdata` into the owner's rdata register and go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle, then go to IDLE.
- Arbitration is round-robin over the 2 ports:
  - If both ports request, the port that is not `owner` wins.
  - A single requester always wins.
  - `owner` resets to 1, so port 0 wins the first tie.
- Request fields need only be stable up to the grant edge; they are latched there.
- A requester must deassert req in the cycle after its ack. A req still high in IDLE is a new request.
- The non-granted port keeps waiting. Its req is not lost; it is evaluated again in the next IDLE.
- `mem_wea` is 0 and `mem_we` is 0 in every cycle where `mem_req` is 0.

## Timing
- Reset values:
  - state = IDLE, counter = 0, `owner` = 1.
  - All acks, `mem_req`, `mem_we`, `mem_wea`, `mem_addr`, `mem_wdata`, both rdata registers and `busy` = 0.
- Reset mid-operation:
  - Any in-flight access is abandoned and no ack is issued.
  - `mem_req` drops asynchronously.
- Write latency: req sampled at edge k, `mem_req` in cycle k+1, ack in cycle k+2.
- Read latency: `mem_req` in cycle k+1, ack in cycle k+2+`RD_LAT` (3 cycles for `RD_LAT` = 1).
- Throughput: a new grant is possible on the edge that leaves DONE→IDLE + 1. Back-to-back writes take 3 cycles per access.
- If both reqs rise in the same cycle, both accesses complete in sequence. The second grant's `mem_req` comes 3 cycles (write) or 3+`RD_LAT` cycles (read) after the first.
- `cpu_stall` is combinational, with no register between `p0_req` and the stall.

## Structure
- Shared package holds:
  - state encodings `ST_IDLE`=0, `ST_ACCESS`=1, `ST_WAIT`=2, `ST_DONE`=3;
  - port IDs `PORT_CPU`=0, `PORT_DBG`=1;
  - `RD_LAT_MAX`=15.
- One combinational sub-module, `rr_pick2`:
  - inputs: 2 reqs and the last owner;
  - outputs: a grant-valid bit and the grant index.
- The FSM, counter, field latches and rdata registers stay in `dm_bus_arbiter`.

## Test plan
- Reset during WAIT of a p0 read at `addr` 0x10 -> all outputs 0 immediately. After release, no p0 ack appears and IDLE accepts a new request.
- Single p0 write, `addr` 0x20, `wdata` 0xDEADBEEF, `wea` 4'b1111 -> `mem_req` with those values exactly once in cycle k+1, then `p0_ack` in k+2 and `cpu_stall` low in k+2.
- p1 read of `addr` 0x08 with `RD_LAT`=3, memory returning 0x12345678 -> `p1_ack` in cycle k+5 with `p1_rdata`=0x12345678, held after ack. `mem_wea`=0 throughout.
- p0 and p1 both request from reset, p0 read and p1 write -> p0 served first, then p1. A third simultaneous pair is served p0 first again, since `owner` = 1 after p1.
- p0 holds req through its ack cycle and keeps it high one more cycle -> a second, distinct access is issued. Verifies the req-drop rule and that exactly one `mem_req` is seen per grant.
- `RD_LAT`=1 vs 15 sweep of reads -> ack spacing from `mem_req` equals `RD_LAT`+1 cycles, and `busy` stays high from the grant edge through DONE.

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared state encodings, port identifiers and latency limits for the
// data-memory bus arbiter.
package dm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int RD_LAT_MAX = 15;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins,
// a lone requester always wins.
module rr_pick2
  import dm_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = last;
    case (req)
      2'b01:   idx = PORT_CPU;
      2'b10:   idx = PORT_DBG;
      2'b11:   idx = ~last;
      default: idx = last;
    endcase
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Shares the data-memory/MIO bus between the CPU data port and a loader/debug
// master; each grant becomes one sequenced access with a one-cycle ack.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_wea,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_ack,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_wea,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_ack,
  output logic [31:0]   p1_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          owner
);

  // Out-of-range latencies are clamped so the counter can never wrap.
  localparam int LAT_CLAMP = (RD_LAT < 1) ? 1 :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_CLAMP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic            owner_reg;
  logic            we_reg;
  logic [3:0]      wea_reg;
  logic [AW-1:0]   addr_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     rdata0_reg, rdata1_reg;
  logic            gnt_valid, gnt_idx;

  rr_pick2 u_pick (
    .req   ({p1_req, p0_req}),
    .last  (owner_reg),
    .valid (gnt_valid),
    .idx   (gnt_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Bus strobes and acks decode straight from the state register so reset
  // removes them without waiting for a clock edge.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_wea    = 4'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    case (state_reg)
      ST_IDLE:   if (gnt_valid) state_next = ST_ACCESS;
      ST_ACCESS: begin
        mem_req    = 1'b1;
        mem_we     = we_reg;
        mem_wea    = we_reg ? wea_reg : 4'b0;
        state_next = we_reg ? ST_DONE : ST_WAIT;
      end
      ST_WAIT:   if (cnt_reg <= CNT_ONE) state_next = ST_DONE;
      ST_DONE: begin
        p0_ack     = (owner_reg == PORT_CPU);
        p1_ack     = (owner_reg == PORT_DBG);
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      owner_reg  <= PORT_DBG;
      we_reg     <= 1'b0;
      wea_reg    <= 4'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (gnt_valid) begin
          owner_reg <= gnt_idx;
          we_reg    <= gnt_idx ? p1_we    : p0_we;
          wea_reg   <= gnt_idx ? p1_wea   : p0_wea;
          addr_reg  <= gnt_idx ? p1_addr  : p0_addr;
          wdata_reg <= gnt_idx ? p1_wdata : p0_wdata;
        end
        ST_ACCESS: if (!we_reg) cnt_reg <= LAT_LOAD;
        ST_WAIT: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg <= CNT_ONE) begin
            if (owner_reg == PORT_DBG) rdata1_reg <= mem_rdata;
            else                       rdata0_reg <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign owner     = owner_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign p0_rdata  = rdata0_reg;
  assign p1_rdata  = rdata1_reg;
  assign cpu_stall = p0_req & ~p0_ack;

endmodule
